// File: rtl/ic74595_pkg.sv
// ---------------------------------------------------------------------------
// ic74595_pkg
// Shared definitions for the 74x595 chain driver and its phase timer.
//   - state_t         : driver FSM states
//   - BITS_PER_CHIP   : width of one 74x595 stage
//   - transfer_cycles : clk cycles from the accept edge to the end of LATCH
// ---------------------------------------------------------------------------
package ic74595_pkg;

  localparam int BITS_PER_CHIP = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  // Every bit costs one low and one high SRCLK half-period, and the latch
  // pulse costs one more half-period.
  function automatic int transfer_cycles(input int width, input int clk_div);
    return (2 * width + 1) * clk_div;
  endfunction

endpackage

// File: rtl/ic74595_tick.sv
// ---------------------------------------------------------------------------
// ic74595_tick
// Loadable down-counter that times one SRCLK/RCLK half-period.
// Loading restarts the count; phase_end is high during the last of the
// CLK_DIV cycles that follow a load.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   load      : restart the half-period (asserted on every state change)
//   phase_end : current half-period finishes at the next rising edge
// ---------------------------------------------------------------------------
module ic74595_tick
  import ic74595_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic phase_end
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  // Count down from CLK_DIV-1 after each load and rest at zero, so the
  // strobe stays up until the owner reloads it on its next state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign phase_end = (count == '0);

endmodule

// File: rtl/ic74595_chain_driver.sv
// ---------------------------------------------------------------------------
// ic74595_chain_driver
// Transmit-side controller for a daisy chain of 74x595 shift registers.
// A word accepted on valid_i/ready_o is serialised onto ser_o with a divided
// SRCLK, then RCLK is pulsed so the chips present the new word.
// Optional macro IC74595_OE_CTRL_EN adds oe_n_o, which holds the 595 outputs
// disabled until the first word has been latched.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   data_i   : parallel word, 8*N_CHIPS bits
//   valid_i  : data_i valid
//   ready_o  : idle, next word accepted on valid_i
//   ser_o    : to 595 SER
//   srclk_o  : to 595 SRCLK (chips shift on its rising edge)
//   rclk_o   : to 595 RCLK (chips latch on its rising edge)
//   oe_n_o   : to 595 /OE (only with IC74595_OE_CTRL_EN)
//   done_o   : one-cycle pulse when the latch phase completes
// ---------------------------------------------------------------------------
module ic74595_chain_driver
  import ic74595_pkg::*;
#(
  parameter int N_CHIPS   = 1,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BITS_PER_CHIP*N_CHIPS-1:0] data_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  output logic                             ser_o,
  output logic                             srclk_o,
  output logic                             rclk_o,
`ifdef IC74595_OE_CTRL_EN
  output logic                             oe_n_o,
`endif
  output logic                             done_o
);

  localparam int W  = BITS_PER_CHIP * N_CHIPS;
  localparam int BW = $clog2(W + 1);

  state_t        state;
  logic [W-1:0]  shreg;
  logic [W-1:0]  shreg_next;
  logic [BW-1:0] bit_cnt;
  logic          accept;
  logic          phase_end;
  logic          tick_load;

  // The bit on ser_o is always the leading end of the shift register, so
  // shifting toward that end exposes the next bit.
  function automatic logic lead_bit(input logic [W-1:0] v);
    return (MSB_FIRST != 0) ? v[W-1] : v[0];
  endfunction

  assign shreg_next = (MSB_FIRST != 0) ? {shreg[W-2:0], 1'b0}
                                       : {1'b0, shreg[W-1:1]};

  assign accept    = (state == IDLE) && valid_i && ready_o;
  assign tick_load = accept || ((state != IDLE) && phase_end);

  ic74595_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .load      (tick_load),
    .phase_end (phase_end)
  );

  // Driver FSM with registered pin outputs. ser_o only moves on entry to
  // SHIFT_LO (and back to 0 on return to IDLE), giving CLK_DIV cycles of
  // setup and hold around every SRCLK rise. It is left alone during LATCH
  // because the last bit still needs its hold time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      ser_o   <= 1'b0;
      srclk_o <= 1'b0;
      rclk_o  <= 1'b0;
      done_o  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef IC74595_OE_CTRL_EN
      oe_n_o  <= 1'b1;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= data_i;
            ser_o   <= lead_bit(data_i);
            bit_cnt <= '0;
            ready_o <= 1'b0;
            state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            srclk_o <= 1'b1;
            state   <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            srclk_o <= 1'b0;
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(W - 1)) begin
              rclk_o <= 1'b1;
              state  <= LATCH;
            end else begin
              shreg  <= shreg_next;
              ser_o  <= lead_bit(shreg_next);
              state  <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          if (phase_end) begin
            rclk_o  <= 1'b0;
            ser_o   <= 1'b0;
            ready_o <= 1'b1;
            done_o  <= 1'b1;
            bit_cnt <= '0;
            state   <= IDLE;
`ifdef IC74595_OE_CTRL_EN
            oe_n_o  <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
